// File: rtl/dac_sweep_ctrl.sv
// Linear FTW sweep sequencer for the dual-channel sine DAC path.
// A phase accumulator drives the CH1/CH2 ROM addresses. The FTW steps a fixed number of times, with a dwell between steps.
module dac_sweep_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int PHASE_W = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [PHASE_W-1:0] freq_start,
  input  logic [PHASE_W-1:0] freq_step,
  input  logic [CNT_W-1:0]   step_count,
  input  logic [CNT_W-1:0]   dwell,
  input  logic [ADDR_W-1:0]  ch2_phase,
  output logic [ADDR_W-1:0]  rom_addr1,
  output logic [ADDR_W-1:0]  rom_addr2,
  output logic               addr_valid,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   cur_step
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_reg, state_next;
  logic [PHASE_W-1:0]  acc_reg;
  logic [PHASE_W-1:0]  ftw_reg;
  logic [PHASE_W-1:0]  step_reg;
  logic [CNT_W-1:0]    last_step_reg;
  logic [CNT_W-1:0]    dwell_reg;
  logic [CNT_W-1:0]    dwell_cnt_reg;
  logic [CNT_W-1:0]    cur_step_reg;
  logic [ADDR_W-1:0]   ch2_reg;

  logic dwell_last;
  logic on_last_step;
  logic launch;

  assign dwell_last   = (dwell_cnt_reg == dwell_reg - {{(CNT_W-1){1'b0}}, 1'b1});
  assign on_last_step = (cur_step_reg == last_step_reg);
  assign launch       = start && !stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (launch) state_next = RUN;
      RUN:     if (stop) state_next = IDLE;
               else if (dwell_last && on_last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rom_addr1  = '0;
    rom_addr2  = '0;
    addr_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    cur_step   = cur_step_reg;
    case (state_reg)
      RUN: begin
        rom_addr1  = acc_reg[PHASE_W-1 -: ADDR_W];
        rom_addr2  = acc_reg[PHASE_W-1 -: ADDR_W] + ch2_reg;
        addr_valid = 1'b1;
        busy       = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // acc is never cleared between steps, so the phase stays continuous across FTW changes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg       <= '0;
      ftw_reg       <= '0;
      step_reg      <= '0;
      last_step_reg <= '0;
      dwell_reg     <= '0;
      dwell_cnt_reg <= '0;
      cur_step_reg  <= '0;
      ch2_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          acc_reg <= '0;
          if (launch) begin
            ftw_reg       <= freq_start;
            step_reg      <= freq_step;
            last_step_reg <= step_count;
            dwell_reg     <= (dwell == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : dwell;
            ch2_reg       <= ch2_phase;
            dwell_cnt_reg <= '0;
            cur_step_reg  <= '0;
          end
        end
        RUN: begin
          if (stop) begin
            acc_reg       <= '0;
            dwell_cnt_reg <= '0;
            cur_step_reg  <= '0;
          end else begin
            acc_reg <= acc_reg + ftw_reg;
            if (dwell_last) begin
              if (!on_last_step) begin
                ftw_reg       <= ftw_reg + step_reg;
                cur_step_reg  <= cur_step_reg + {{(CNT_W-1){1'b0}}, 1'b1};
                dwell_cnt_reg <= '0;
              end
            end else begin
              dwell_cnt_reg <= dwell_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
        end
        default: acc_reg <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_sweep_ctrl.sv
// Directed testbench for dac_sweep_ctrl.
// Each task drives one scenario and compares the outputs against hand-computed values.
module tb_dac_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] freq_start = '0;
  logic [31:0] freq_step = '0;
  logic [15:0] step_count = '0;
  logic [15:0] dwell = '0;
  logic [9:0]  ch2_phase = '0;
  logic [9:0]  rom_addr1, rom_addr2;
  logic        addr_valid, busy, done;
  logic [15:0] cur_step;

  int errors = 0;
  int checks = 0;

  int t2_addr [12] = '{0, 1, 2, 3, 4, 6, 8, 10, 12, 15, 18, 21};
  int t4_addr [4]  = '{0, 1, 2, 4};
  int t5_addr [3]  = '{0, 1, 3};

  always #4 clk = ~clk;

  dac_sweep_ctrl #(.ADDR_W(10), .PHASE_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .freq_start(freq_start), .freq_step(freq_step), .step_count(step_count),
    .dwell(dwell), .ch2_phase(ch2_phase),
    .rom_addr1(rom_addr1), .rom_addr2(rom_addr2), .addr_valid(addr_valid),
    .busy(busy), .done(done), .cur_step(cur_step)
  );

  task automatic set_cfg(input logic [31:0] fs, input logic [31:0] fstep,
                         input logic [15:0] sc, input logic [15:0] dw, input logic [9:0] ph);
    freq_start = fs; freq_step = fstep; step_count = sc; dwell = dw; ch2_phase = ph;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, addr_valid, done} !== 3'b000 || rom_addr1 !== 10'd0 || rom_addr2 !== 10'd0 || cur_step !== 16'd0) begin
      errors++;
      $display("FAIL reset: got busy=%b valid=%b done=%b a1=%0d a2=%0d step=%0d, want all 0",
               busy, addr_valid, done, rom_addr1, rom_addr2, cur_step);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, addr_valid, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release: got busy=%b valid=%b done=%b, want 000", busy, addr_valid, done);
    end
    $display("test_reset finished");
  endtask

  task automatic test_single_step();
    set_cfg(32'h0040_0000, 32'h0, 16'd0, 16'd8, 10'd256);
    pulse_start();
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if ({busy, addr_valid, done} !== 3'b110 || rom_addr1 !== 10'(c-1) ||
          rom_addr2 !== 10'(256+c-1) || cur_step !== 16'd0) begin
        errors++;
        $display("FAIL single_run c=%0d: got b/v/d=%b%b%b a1=%0d a2=%0d step=%0d, want 110 a1=%0d a2=%0d step=0",
                 c, busy, addr_valid, done, rom_addr1, rom_addr2, cur_step, c-1, 256+c-1);
      end
      @(negedge clk);
    end
    checks++;
    if ({busy, addr_valid, done} !== 3'b001 || rom_addr1 !== 10'd0 || rom_addr2 !== 10'd0) begin
      errors++;
      $display("FAIL single_done: got b/v/d=%b%b%b a1=%0d a2=%0d, want 001 0 0",
               busy, addr_valid, done, rom_addr1, rom_addr2);
    end
    @(negedge clk);
    checks++;
    if ({busy, addr_valid, done} !== 3'b000) begin
      errors++;
      $display("FAIL single_after: got b/v/d=%b%b%b, want 000", busy, addr_valid, done);
    end
    $display("test_single_step finished");
  endtask

  task automatic test_multi_step();
    set_cfg(32'h0040_0000, 32'h0040_0000, 16'd2, 16'd4, 10'd0);
    pulse_start();
    for (int c = 1; c <= 12; c++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || rom_addr1 !== 10'(t2_addr[c-1]) || cur_step !== 16'((c-1)/4)) begin
        errors++;
        $display("FAIL multi_run c=%0d: got busy=%b done=%b a1=%0d step=%0d, want 1 0 a1=%0d step=%0d",
                 c, busy, done, rom_addr1, cur_step, t2_addr[c-1], (c-1)/4);
      end
      @(negedge clk);
    end
    checks++;
    if ({busy, done} !== 2'b01) begin
      errors++;
      $display("FAIL multi_done: got busy=%b done=%b, want 0 1", busy, done);
    end
    @(negedge clk);
    $display("test_multi_step finished");
  endtask

  task automatic test_wrap();
    set_cfg(32'h8000_0000, 32'h0, 16'd0, 16'd6, 10'd1023);
    pulse_start();
    for (int c = 1; c <= 6; c++) begin
      checks++;
      if (rom_addr1 !== ((c % 2 == 1) ? 10'd0 : 10'd512) ||
          rom_addr2 !== ((c % 2 == 1) ? 10'd1023 : 10'd511) || busy !== 1'b1) begin
        errors++;
        $display("FAIL wrap c=%0d: got a1=%0d a2=%0d busy=%b, want a1=%0d a2=%0d busy=1",
                 c, rom_addr1, rom_addr2, busy, (c % 2 == 1) ? 0 : 512, (c % 2 == 1) ? 1023 : 511);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL wrap_done: got done=%b, want 1", done);
    end
    @(negedge clk);
    $display("test_wrap finished");
  endtask

  task automatic test_stop();
    set_cfg(32'h0040_0000, 32'h0, 16'd5, 16'd10, 10'd3);
    pulse_start();
    for (int c = 1; c <= 17; c++) begin
      checks++;
      if (busy !== 1'b1 || rom_addr1 !== 10'(c-1) || cur_step !== 16'((c-1)/10)) begin
        errors++;
        $display("FAIL stop_run c=%0d: got busy=%b a1=%0d step=%0d, want 1 %0d %0d",
                 c, busy, rom_addr1, cur_step, c-1, (c-1)/10);
      end
      if (c == 17) stop = 1'b1;
      @(negedge clk);
    end
    stop = 1'b0;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if ({busy, addr_valid, done} !== 3'b000 || rom_addr1 !== 10'd0 || rom_addr2 !== 10'd0) begin
        errors++;
        $display("FAIL stop_idle c=%0d: got b/v/d=%b%b%b a1=%0d a2=%0d, want 000 0 0",
                 c, busy, addr_valid, done, rom_addr1, rom_addr2);
      end
      @(negedge clk);
    end
    set_cfg(32'h0040_0000, 32'h0040_0000, 16'd1, 16'd2, 10'd0);
    pulse_start();
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (busy !== 1'b1 || rom_addr1 !== 10'(t4_addr[c-1]) || cur_step !== 16'((c-1)/2)) begin
        errors++;
        $display("FAIL restart_run c=%0d: got busy=%b a1=%0d step=%0d, want 1 %0d %0d",
                 c, busy, rom_addr1, cur_step, t4_addr[c-1], (c-1)/2);
      end
      @(negedge clk);
    end
    checks++;
    if ({busy, done} !== 2'b01) begin
      errors++;
      $display("FAIL restart_done: got busy=%b done=%b, want 0 1", busy, done);
    end
    @(negedge clk);
    $display("test_stop finished");
  endtask

  task automatic test_corner_cases();
    // start re-pulsed mid-run with different settings must be ignored
    set_cfg(32'h0040_0000, 32'h0, 16'd1, 16'd3, 10'd0);
    pulse_start();
    set_cfg(32'h0100_0000, 32'h0, 16'd7, 16'd9, 10'd100);
    for (int c = 1; c <= 6; c++) begin
      checks++;
      if (busy !== 1'b1 || rom_addr1 !== 10'(c-1) || rom_addr2 !== 10'(c-1) || cur_step !== 16'((c-1)/3)) begin
        errors++;
        $display("FAIL restart_ignored c=%0d: got busy=%b a1=%0d a2=%0d step=%0d, want 1 %0d %0d %0d",
                 c, busy, rom_addr1, rom_addr2, cur_step, c-1, c-1, (c-1)/3);
      end
      start = (c == 2);
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if ({busy, done} !== 2'b01) begin
      errors++;
      $display("FAIL restart_ignored_done: got busy=%b done=%b, want 0 1", busy, done);
    end
    @(negedge clk);
    $display("test_corner_cases restart-ignore finished");

    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({busy, addr_valid, done} !== 3'b000) begin
        errors++;
        $display("FAIL start_stop_idle c=%0d: got b/v/d=%b%b%b, want 000", c, busy, addr_valid, done);
      end
      @(negedge clk);
    end
    $display("test_corner_cases start+stop finished");

    set_cfg(32'h0040_0000, 32'h0040_0000, 16'd2, 16'd0, 10'd0);
    pulse_start();
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (busy !== 1'b1 || rom_addr1 !== 10'(t5_addr[c-1]) || cur_step !== 16'(c-1)) begin
        errors++;
        $display("FAIL dwell0 c=%0d: got busy=%b a1=%0d step=%0d, want 1 %0d %0d",
                 c, busy, rom_addr1, cur_step, t5_addr[c-1], c-1);
      end
      @(negedge clk);
    end
    checks++;
    if ({busy, done} !== 2'b01) begin
      errors++;
      $display("FAIL dwell0_done: got busy=%b done=%b, want 0 1", busy, done);
    end
    @(negedge clk);
    $display("test_corner_cases dwell0 finished");
  endtask

  task automatic test_async_reset();
    set_cfg(32'h0040_0000, 32'h0, 16'd0, 16'd100, 10'd5);
    pulse_start();
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || rom_addr1 !== 10'd5 || rom_addr2 !== 10'd10) begin
      errors++;
      $display("FAIL areset_pre: got busy=%b a1=%0d a2=%0d, want 1 5 10", busy, rom_addr1, rom_addr2);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, addr_valid, done} !== 3'b000 || rom_addr1 !== 10'd0 || rom_addr2 !== 10'd0 || cur_step !== 16'd0) begin
      errors++;
      $display("FAIL areset_now: got b/v/d=%b%b%b a1=%0d a2=%0d step=%0d, want all 0",
               busy, addr_valid, done, rom_addr1, rom_addr2, cur_step);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({busy, addr_valid, done} !== 3'b000) begin
        errors++;
        $display("FAIL areset_idle c=%0d: got b/v/d=%b%b%b, want 000", c, busy, addr_valid, done);
      end
    end
    pulse_start();
    checks++;
    if (busy !== 1'b1 || rom_addr1 !== 10'd0 || rom_addr2 !== 10'd5) begin
      errors++;
      $display("FAIL areset_restart: got busy=%b a1=%0d a2=%0d, want 1 0 5", busy, rom_addr1, rom_addr2);
    end
    @(negedge clk);
    checks++;
    if (rom_addr1 !== 10'd1 || rom_addr2 !== 10'd6) begin
      errors++;
      $display("FAIL areset_restart2: got a1=%0d a2=%0d, want 1 6", rom_addr1, rom_addr2);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    $display("test_async_reset finished");
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_multi_step();
    test_wrap();
    test_stop();
    test_corner_cases();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dac_sweep_ctrl.md
Name: dac_sweep_ctrl

Overview:
Sequencer for the dual-channel AD9767 sine path. A 32-bit phase accumulator drives the 10-bit sine ROM addresses of CH1 and CH2, with a programmable CH2 phase offset. The frequency tuning word (FTW) is stepped through a linear sweep: a fixed number of steps, each held for a programmable dwell time. The block sits between register/control logic and the ROM instances, in the 125 MHz DAC clock domain.

Parameters:
ADDR_W, 10, ROM address width (1024-entry sine table)
PHASE_W, 32, phase accumulator and FTW width
CNT_W, 16, width of step-count and dwell counters

Ports:
clk  in  1  125 MHz DAC clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins a sweep when idle
stop  in  1  single-cycle pulse; aborts a running sweep
freq_start  in  PHASE_W  FTW of step 0
freq_step  in  PHASE_W  FTW increment per step
step_count  in  CNT_W  index of last step (total steps = step_count+1)
dwell  in  CNT_W  cycles per step (0 treated as 1)
ch2_phase  in  ADDR_W  CH2 address offset relative to CH1
rom_addr1  out  ADDR_W  CH1 ROM address
rom_addr2  out  ADDR_W  CH2 ROM address
addr_valid  out  1  high while addresses belong to an active sweep
busy  out  1  high in RUN
done  out  1  one-cycle pulse on normal sweep completion
cur_step  out  CNT_W  index of the step in progress

Behaviour:
- Reset (async, rst_n=0): state=IDLE; acc=0; ftw=0; all outputs 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - acc held at 0; rom_addr1=0; rom_addr2=0; addr_valid=0; busy=0.
  - start=1 and stop=0: latch freq_start into ftw; latch freq_step, step_count, max(dwell,1) and ch2_phase into shadow registers; clear acc, dwell counter and cur_step; go to RUN.
  - start and stop asserted together in IDLE: stop wins; remain in IDLE.
- RUN:
  - Each cycle: acc <= acc + ftw, modulo 2^PHASE_W.
  - rom_addr1 = acc[PHASE_W-1 -: ADDR_W].
  - rom_addr2 = (rom_addr1 + ch2_phase_latched) mod 2^ADDR_W.
  - addr_valid=1; busy=1.
  - Dwell counter increments each cycle. On its final cycle (count = dwell-1):
    - if cur_step == step_count: go to DONE;
    - otherwise ftw <= ftw + freq_step (wraps mod 2^PHASE_W), cur_step++, dwell counter cleared.
  - The new FTW takes effect on the acc update of the following cycle. acc is never cleared between steps, so phase is continuous.
- DONE: single cycle; done=1, busy=0, addr_valid=0; return to IDLE.
- Timing:
  - start sampled at edge N: busy=1 from N+1.
  - Address at N+1 is 0; address at N+2 is ftw0[31:22].
  - RUN lasts exactly (step_count+1)*max(dwell,1) cycles.
- stop in RUN: highest priority, including over dwell expiry on the same cycle. Next state is IDLE; no done pulse; outputs return to IDLE values.
- start while in RUN or DONE: ignored.
- Inputs are sampled only at start. Changes during RUN have no effect.
- Output frequency: f = ftw * 125e6 / 2^32. ftw=0x00400000 gives about 122 kHz.
- The ROM adds 1 cycle of latency. Downstream logic delays addr_valid by 1 cycle to qualify rom_data.

Test Plan:
1. freq_start=0x00400000, step_count=0, dwell=8, ch2_phase=256, start pulse -> rom_addr1 = 0..7 and rom_addr2 = 256..263 on consecutive cycles; done pulses exactly once, 9 cycles after start sampled; busy high for 8 cycles.
2. freq_start=0x00400000, freq_step=0x00400000, step_count=2, dwell=4 -> per-cycle rom_addr1 deltas of 1 (×4), 2 (×4), 3 (×4); cur_step 0,1,2; 12 RUN cycles then done; no phase reset at step boundaries.
3. freq_start=0x80000000, ch2_phase=1023, dwell=6 -> rom_addr1 alternates 0,512; rom_addr2 alternates 1023,511 (mod-1024 wrap).
4. step_count=5, dwell=10, stop asserted at RUN cycle 17 -> IDLE next cycle; addresses 0; no done pulse; a new start then runs a normal sweep from step 0.
5. Three cases: start re-pulsed during RUN -> no restart and cur_step unaffected; start+stop together in IDLE -> stays IDLE; dwell=0 -> behaves as dwell=1.
6. rst_n low asynchronously mid-RUN (between clock edges) -> all outputs 0 immediately. After release, IDLE until the next start.
